// File: rtl/sipo_rx_pkg.sv
// -----------------------------------------------------------------------------
// sipo_rx_pkg
// Shared definitions for the serial-to-parallel frame receiver.
//   rx_state_e  : receiver FSM states (idle / shifting data bits)
//   START_LEVEL : line level that marks a start bit (line idles at 0)
// -----------------------------------------------------------------------------
package sipo_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  localparam logic START_LEVEL = 1'b1;

endpackage : sipo_rx_pkg

// File: rtl/sipo_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus bit counter for one frame's data bits.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart the bit counter (asserted when a start bit is seen)
//   shift_en   : shift serial_in in on this edge
//   serial_in  : serial data bit
//   word       : word as it will be after this edge's shift, so the parent can
//                capture the complete frame on the same edge as the last bit
//   last_bit   : this edge samples the final data bit of the frame
// -----------------------------------------------------------------------------
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    count_reg;

  // First received bit migrates to the MSB (MSB-first) or the LSB (LSB-first)
  // after WIDTH shifts.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
      assign shift_next = {serial_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign word     = shift_next;
  assign last_bit = shift_en && (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      count_reg <= '0;
    end else begin
      if (shift_en) begin
        shift_reg <= shift_next;
      end
      // Counter only restarts when a new frame begins; it parks at WIDTH
      // between frames.
      if (clear) begin
        count_reg <= '0;
      end else if (shift_en) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule : sipo_shift_core

// File: rtl/sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver
// Detects a start bit on a serial line, deserialises the following WIDTH bits
// and offers the word on a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   serial_in   : serial bitstream, one bit per clock, idles at 0
//   data_out    : received word, held stable while data_valid=1
//   data_valid  : word available
//   data_ready  : consumer accepts the word on data_valid & data_ready
//   busy        : frame data bits are being shifted in
//   overrun     : sticky flag, a completed frame was dropped because the
//                 holding register was still full; cleared by a handshake
// -----------------------------------------------------------------------------
module sipo_frame_receiver
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun
);

  rx_state_e        state_reg;
  rx_state_e        state_next;
  logic [WIDTH-1:0] data_out_reg;
  logic             data_valid_reg;
  logic             overrun_reg;

  logic             start_seen;
  logic             shift_en;
  logic             frame_done;
  logic [WIDTH-1:0] frame_word;
  logic             handshake;
  logic             drop;

  assign start_seen = (state_reg == ST_IDLE) && (serial_in == START_LEVEL);
  assign shift_en   = (state_reg == ST_SHIFT);
  assign handshake  = data_valid_reg && data_ready;
  // A completed frame is lost only if the held word is not leaving this edge.
  assign drop       = frame_done && data_valid_reg && !data_ready;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_seen),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .word      (frame_word),
    .last_bit  (frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_seen) state_next = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (frame_done && !drop) begin
        data_out_reg   <= frame_word;
        data_valid_reg <= 1'b1;
      end else if (handshake) begin
        data_valid_reg <= 1'b0;
      end
      // A drop on the same edge as a handshake cannot happen (drop needs
      // data_ready=0), so a drop always wins over the clear.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (handshake) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign overrun    = overrun_reg;
  assign busy       = (state_reg == ST_SHIFT);

endmodule : sipo_frame_receiver
